div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 152 +++++++++++++++
 tb/tb_div_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative restoring divider, signed/unsigned, one quotient bit per cycle.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips CALC and completes right after accept.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic             cancel,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   prem_q, prem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             qbit;
    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_quo;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? (~x + ONE) : x;
    endfunction

    // The dividend register doubles as the quotient: dividend bits shift out the top
    // while quotient bits shift in at the bottom.
    always_comb begin
        shifted  = {prem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
        diff     = shifted - {1'b0, dvs_q};
        qbit     = ~diff[WIDTH];
        step_rem = qbit ? diff : shifted;
        step_quo = {dvd_q[WIDTH-2:0], qbit};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prem_d  = prem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = '0;
                    prem_d  = '0;
                    dvd_d   = cond_neg(data1, signed_div & data1[WIDTH-1]);
                    dvs_d   = cond_neg(data2, signed_div & data2[WIDTH-1]);
                    qneg_d  = signed_div & (data1[WIDTH-1] ^ data2[WIDTH-1]);
                    rneg_d  = signed_div & data1[WIDTH-1];
                    dz_d    = (data2 == '0);
                    state_d = CALC;
`ifdef DIV_ZERO_FAST_EN
                    if (data2 == '0) begin
                        state_d = DONE;
                        quot_d  = '1;
                        rem_d   = data1;
                        dbz_d   = 1'b1;
                    end
`endif
                end
            end
            CALC: begin
                if (cancel) begin
                    state_d = IDLE;
                end else begin
                    prem_d = step_rem;
                    dvd_d  = step_quo;
                    cnt_d  = cnt_q + CNT_ONE;
                    if (cnt_q == LAST_CNT) begin
                        // A zero divisor leaves |data1| in the remainder; re-signing restores data1.
                        state_d = DONE;
                        quot_d  = dz_q ? '1 : cond_neg(step_quo, qneg_q);
                        rem_d   = cond_neg(step_rem[WIDTH-1:0], rneg_q);
                        dbz_d   = dz_q;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prem_q  <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prem_q  <= prem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == CALC);
    assign ready       = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected results, a monitor checks each ready pulse.
module tb_div_unit;

    localparam int W = 32;
`ifdef DIV_ZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         signed_div = 1'b0;
    logic [W-1:0] data1 = '0;
    logic [W-1:0] data2 = '0;
    logic         cancel = 1'b0;
    logic         busy, ready, div_by_zero;
    logic [W-1:0] quotient, remainder;

    div_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_div(signed_div),
        .data1(data1), .data2(data2), .cancel(cancel), .busy(busy), .ready(ready),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           edge_no;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_fail = 0;

    function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("quotient", quotient, e.q);
                    chk("remainder", remainder, e.r);
                    chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
                    chk("ready_edge", W'(edge_cnt), W'(e.edge_no));
                end
            end
        end
    end

    task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                         input bit expect_it);
        exp_t e;
        @(negedge clk);
        start = 1'b1; signed_div = sgn; data1 = a; data2 = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (expect_it) begin
            e.q = eq; e.r = er; e.dz = edz;
            e.edge_no = edge_cnt + ((FAST && b == '0) ? 0 : W);
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", W'(sb.size()), '0);
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_quotient", quotient, '0);
        chk("rst_remainder", remainder, '0);
        chk("rst_dbz", {31'd0, div_by_zero}, '0);
        chk("rst_busy", {31'd0, busy}, '0);
        chk("rst_ready", {31'd0, ready}, '0);
        rst_n = 1'b1;

        // Directed vectors with hand-computed results
        issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        drain();
        issue(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b1);
        drain();
        issue(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 1'b1);
        drain();
        issue(1'b0, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1'b1, 1'b1);
        chk("busy_div0", {31'd0, busy}, FAST ? 32'd0 : 32'd1);
        drain();
        issue(1'b1, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1'b1, 1'b1);
        drain();
        issue(1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 1'b1);
        drain();
        issue(1'b1, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, 1'b0, 1'b1);
        drain();
        issue(1'b0, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 32'hF, 1'b0, 1'b1);
        drain();
        issue(1'b1, 32'h80000000, 32'd0, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b1);
        drain();

        // Cancel at cycle 10 of CALC: no ready, results untouched, then 50 / 5
        issue(1'b0, 32'd1000, 32'd3, '0, '0, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        chk("cancel_busy", {31'd0, busy}, '0);
        repeat (40) @(negedge clk);
        chk("cancel_hold_q", quotient, 32'hFFFFFFFF);
        chk("cancel_hold_r", remainder, 32'h80000000);
        issue(1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 1'b1);
        drain();

        // A second start during CALC is ignored
        issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        start = 1'b1; data1 = 32'd9; data2 = 32'd3;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (40) @(negedge clk);

        // Reset at cycle 5 of CALC, then start on the first edge after release
        issue(1'b0, 32'd1000, 32'd3, '0, '0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_quotient", quotient, '0);
        chk("midrst_remainder", remainder, '0);
        chk("midrst_dbz", {31'd0, div_by_zero}, '0);
        chk("midrst_busy", {31'd0, busy}, '0);
        chk("midrst_ready", {31'd0, ready}, '0);
        repeat (40) @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1; signed_div = 1'b0; data1 = 32'd50; data2 = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("post_rst_accept", {31'd0, busy}, 32'd1);
        begin
            exp_t e;
            e.q = 32'd10; e.r = 32'd0; e.dz = 1'b0; e.edge_no = edge_cnt + W;
            sb.push_back(e);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
